// File: rtl/maze_state_tracker_if.sv
// rtl/maze_state_tracker_if.sv - action/update bundle between the agent, the maze tracker and the state decoder
interface maze_state_tracker_if;
    logic       start;
    logic       act_valid;
    logic [1:0] act;
    logic       act_ready;
    logic [3:0] at;
    logic       upd_valid;
    logic [1:0] upd_act;
    logic [3:0] s_next;
    logic [7:0] reward;
    logic       done;
    logic [7:0] step_cnt;
    logic [15:0] episode_cnt;

    modport master (
        output start, act_valid, act,
        input  act_ready, at, upd_valid, upd_act, s_next, reward, done, step_cnt, episode_cnt
    );

    modport slave (
        input  start, act_valid, act,
        output act_ready, at, upd_valid, upd_act, s_next, reward, done, step_cnt, episode_cnt
    );
endinterface

// File: rtl/maze_state_tracker.sv
// rtl/maze_state_tracker.sv - 5x3 grid maze state register: applies actions, produces next cell, reward and episode end
module maze_state_tracker #(
    parameter logic [3:0]        START_CELL = 4'd1,
    parameter logic [3:0]        GOAL_CELL  = 4'd15,
    parameter logic [14:0]       WALL_MASK  = 15'b0,
    parameter logic [7:0]        MAX_STEPS  = 8'd100,
    parameter logic signed [7:0] REW_STEP   = -8'sd1,
    parameter logic signed [7:0] REW_WALL   = -8'sd5,
    parameter logic signed [7:0] REW_GOAL   = 8'sd100
) (
    input logic                 clk,
    input logic                 rst,
    maze_state_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  at_q;
    logic [3:0]  s_next_q;
    logic [7:0]  reward_q;
    logic [1:0]  upd_act_q;
    logic        upd_valid_q;
    logic        done_q;
    logic [7:0]  step_cnt_q;
    logic [15:0] episode_cnt_q;

    // Padding bit 15 keeps the wall lookup in range for any 4-bit index.
    logic [15:0] wall_vec;
    logic [3:0]  cidx;
    logic [3:0]  tgt;
    logic [3:0]  wall_idx;
    logic        off_grid;
    logic        blocked;
    logic [3:0]  mv_next;
    logic [7:0]  mv_reward;

    assign wall_vec = {1'b0, WALL_MASK};

    always_comb begin
        tgt      = at_q;
        off_grid = 1'b0;
        if (at_q > 4'd10) begin
            cidx = at_q - 4'd11;
        end else if (at_q > 4'd5) begin
            cidx = at_q - 4'd6;
        end else begin
            cidx = at_q - 4'd1;
        end
        case (bus.act)
            2'd0: begin
                if (at_q > 4'd5) tgt = at_q - 4'd5;
                else off_grid = 1'b1;
            end
            2'd1: begin
                if (cidx != 4'd4) tgt = at_q + 4'd1;
                else off_grid = 1'b1;
            end
            2'd2: begin
                if (at_q <= 4'd10) tgt = at_q + 4'd5;
                else off_grid = 1'b1;
            end
            default: begin
                if (cidx != 4'd0) tgt = at_q - 4'd1;
                else off_grid = 1'b1;
            end
        endcase
        wall_idx = tgt - 4'd1;
        blocked  = off_grid || wall_vec[wall_idx];
        if (blocked) begin
            mv_next   = at_q;
            mv_reward = REW_WALL;
        end else begin
            mv_next   = tgt;
            mv_reward = (tgt == GOAL_CELL) ? REW_GOAL : REW_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            at_q          <= 4'd0;
            s_next_q      <= 4'd0;
            reward_q      <= 8'd0;
            upd_act_q     <= 2'd0;
            upd_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            step_cnt_q    <= 8'd0;
            episode_cnt_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        at_q       <= START_CELL;
                        step_cnt_q <= 8'd0;
                    end
                end
                RUN: begin
                    if (bus.act_valid) begin
                        state       <= UPDATE;
                        upd_valid_q <= 1'b1;
                        s_next_q    <= mv_next;
                        reward_q    <= mv_reward;
                        upd_act_q   <= bus.act;
                        step_cnt_q  <= step_cnt_q + 8'd1;
                    end
                end
                UPDATE: begin
                    // at stays on the pre-move cell during UPDATE so the decoder writes the right Q entry.
                    upd_valid_q <= 1'b0;
                    at_q        <= s_next_q;
                    if ((s_next_q == GOAL_CELL) || (step_cnt_q == MAX_STEPS)) begin
                        state         <= DONE;
                        done_q        <= 1'b1;
                        episode_cnt_q <= episode_cnt_q + 16'd1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    done_q     <= 1'b0;
                    state      <= RUN;
                    at_q       <= START_CELL;
                    step_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign bus.act_ready   = (state == RUN);
    assign bus.at          = at_q;
    assign bus.s_next      = s_next_q;
    assign bus.reward      = reward_q;
    assign bus.upd_act     = upd_act_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.done        = done_q;
    assign bus.step_cnt    = step_cnt_q;
    assign bus.episode_cnt = episode_cnt_q;

endmodule

// File: tb/tb_maze_state_tracker.sv
// tb/tb_maze_state_tracker.sv - directed self-checking bench for maze_state_tracker
module tb_maze_state_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    maze_state_tracker_if b0 ();
    maze_state_tracker_if b1 ();
    maze_state_tracker_if b2 ();

    maze_state_tracker u0 (.clk(clk), .rst(rst), .bus(b0));
    maze_state_tracker #(.WALL_MASK(15'b000_0000_0000_0010)) u1 (.clk(clk), .rst(rst), .bus(b1));
    maze_state_tracker #(.GOAL_CELL(4'd4), .MAX_STEPS(8'd3)) u2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted action on b0, ending back in RUN two cycles later.
    task automatic go0(input logic [1:0] a);
        b0.act_valid = 1'b1;
        b0.act = a;
        tick();
        b0.act_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (b0.at !== 4'd0) begin failures++; $display("FAIL reset_at got=%0d exp=0", b0.at); end
        checks++; if (b0.act_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", b0.act_ready); end
        checks++; if ({b0.upd_valid, b0.done} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%0b exp=0", {b0.upd_valid, b0.done}); end
        checks++; if ({b0.s_next, b0.reward, b0.upd_act} !== 14'd0) begin failures++; $display("FAIL reset_upd got=%0h exp=0", {b0.s_next, b0.reward, b0.upd_act}); end
        checks++; if ({b0.step_cnt, b0.episode_cnt} !== 24'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", {b0.step_cnt, b0.episode_cnt}); end
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        checks++; if (b0.at !== 4'd1) begin failures++; $display("FAIL start_at got=%0d exp=1", b0.at); end
        checks++; if (b0.act_ready !== 1'b1) begin failures++; $display("FAIL start_ready got=%0b exp=1", b0.act_ready); end
    endtask

    task automatic test_move();
        b0.act_valid = 1'b1;
        b0.act = 2'd1;
        tick();
        b0.act_valid = 1'b0;
        checks++; if (b0.upd_valid !== 1'b1) begin failures++; $display("FAIL move_uv got=%0b exp=1", b0.upd_valid); end
        checks++; if (b0.at !== 4'd1) begin failures++; $display("FAIL move_at got=%0d exp=1", b0.at); end
        checks++; if (b0.s_next !== 4'd2) begin failures++; $display("FAIL move_snext got=%0d exp=2", b0.s_next); end
        checks++; if (b0.reward !== 8'hFF) begin failures++; $display("FAIL move_reward got=%0h exp=ff", b0.reward); end
        checks++; if (b0.step_cnt !== 8'd1) begin failures++; $display("FAIL move_step got=%0d exp=1", b0.step_cnt); end
        checks++; if (b0.upd_act !== 2'd1) begin failures++; $display("FAIL move_act got=%0d exp=1", b0.upd_act); end
        checks++; if (b0.act_ready !== 1'b0) begin failures++; $display("FAIL move_ready got=%0b exp=0", b0.act_ready); end
        tick();
        checks++; if (b0.at !== 4'd2) begin failures++; $display("FAIL move_at2 got=%0d exp=2", b0.at); end
        checks++; if (b0.upd_valid !== 1'b0) begin failures++; $display("FAIL move_uv2 got=%0b exp=0", b0.upd_valid); end
    endtask

    task automatic test_edge();
        go0(2'd3);
        checks++; if (b0.at !== 4'd1) begin failures++; $display("FAIL edge_left got=%0d exp=1", b0.at); end
        b0.act_valid = 1'b1;
        b0.act = 2'd0;
        tick();
        b0.act_valid = 1'b0;
        checks++; if (b0.s_next !== 4'd1) begin failures++; $display("FAIL edge_snext got=%0d exp=1", b0.s_next); end
        checks++; if (b0.reward !== 8'hFB) begin failures++; $display("FAIL edge_reward got=%0h exp=fb", b0.reward); end
        checks++; if (b0.step_cnt !== 8'd3) begin failures++; $display("FAIL edge_step got=%0d exp=3", b0.step_cnt); end
        tick();
        checks++; if (b0.at !== 4'd1) begin failures++; $display("FAIL edge_at got=%0d exp=1", b0.at); end
    endtask

    task automatic test_goal();
        go0(2'd2);
        go0(2'd2);
        go0(2'd1);
        go0(2'd1);
        go0(2'd1);
        checks++; if (b0.at !== 4'd14) begin failures++; $display("FAIL goal_path got=%0d exp=14", b0.at); end
        b0.act_valid = 1'b1;
        b0.act = 2'd1;
        tick();
        b0.act = 2'd0;
        checks++; if (b0.s_next !== 4'd15) begin failures++; $display("FAIL goal_snext got=%0d exp=15", b0.s_next); end
        checks++; if (b0.reward !== 8'h64) begin failures++; $display("FAIL goal_reward got=%0h exp=64", b0.reward); end
        checks++; if (b0.step_cnt !== 8'd9) begin failures++; $display("FAIL goal_step got=%0d exp=9", b0.step_cnt); end
        tick();
        checks++; if (b0.done !== 1'b1) begin failures++; $display("FAIL goal_done got=%0b exp=1", b0.done); end
        checks++; if (b0.at !== 4'd15) begin failures++; $display("FAIL goal_at got=%0d exp=15", b0.at); end
        checks++; if (b0.episode_cnt !== 16'd1) begin failures++; $display("FAIL goal_ep got=%0d exp=1", b0.episode_cnt); end
        checks++; if (b0.act_ready !== 1'b0) begin failures++; $display("FAIL goal_ready got=%0b exp=0", b0.act_ready); end
        checks++; if (b0.step_cnt !== 8'd9) begin failures++; $display("FAIL goal_ignore got=%0d exp=9", b0.step_cnt); end
        tick();
        b0.act_valid = 1'b0;
        checks++; if (b0.done !== 1'b0) begin failures++; $display("FAIL goal_done2 got=%0b exp=0", b0.done); end
        checks++; if (b0.at !== 4'd1) begin failures++; $display("FAIL goal_restart got=%0d exp=1", b0.at); end
        checks++; if (b0.step_cnt !== 8'd0) begin failures++; $display("FAIL goal_step0 got=%0d exp=0", b0.step_cnt); end
        checks++; if (b0.upd_valid !== 1'b0) begin failures++; $display("FAIL goal_uv got=%0b exp=0", b0.upd_valid); end
    endtask

    task automatic test_back_to_back();
        b0.act_valid = 1'b1;
        b0.act = 2'd1;
        tick();
        checks++; if ({b0.upd_valid, b0.s_next} !== {1'b1, 4'd2}) begin failures++; $display("FAIL b2b_first got=%0h exp=12", {b0.upd_valid, b0.s_next}); end
        tick();
        checks++; if ({b0.act_ready, b0.at} !== {1'b1, 4'd2}) begin failures++; $display("FAIL b2b_run got=%0h exp=12", {b0.act_ready, b0.at}); end
        tick();
        b0.act_valid = 1'b0;
        checks++; if ({b0.upd_valid, b0.s_next, b0.step_cnt} !== {1'b1, 4'd3, 8'd2}) begin failures++; $display("FAIL b2b_second got=%0h exp=1302", {b0.upd_valid, b0.s_next, b0.step_cnt}); end
        tick();
        checks++; if (b0.at !== 4'd3) begin failures++; $display("FAIL b2b_at got=%0d exp=3", b0.at); end
    endtask

    task automatic test_wall();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        checks++; if (b1.at !== 4'd1) begin failures++; $display("FAIL wall_start got=%0d exp=1", b1.at); end
        b1.act_valid = 1'b1;
        b1.act = 2'd1;
        tick();
        b1.act_valid = 1'b0;
        checks++; if (b1.s_next !== 4'd1) begin failures++; $display("FAIL wall_snext got=%0d exp=1", b1.s_next); end
        checks++; if (b1.reward !== 8'hFB) begin failures++; $display("FAIL wall_reward got=%0h exp=fb", b1.reward); end
        tick();
        b1.act_valid = 1'b1;
        b1.act = 2'd2;
        tick();
        b1.act_valid = 1'b0;
        checks++; if (b1.s_next !== 4'd6) begin failures++; $display("FAIL wall_down got=%0d exp=6", b1.s_next); end
        checks++; if (b1.reward !== 8'hFF) begin failures++; $display("FAIL wall_down_rew got=%0h exp=ff", b1.reward); end
        tick();
    endtask

    task automatic test_max_steps();
        logic [1:0] bumps [3];
        bumps[0] = 2'd0;
        bumps[1] = 2'd3;
        bumps[2] = 2'd0;
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b2.act_valid = 1'b1;
            b2.act = bumps[i];
            tick();
            b2.act_valid = 1'b0;
            tick();
        end
        checks++; if (b2.done !== 1'b1) begin failures++; $display("FAIL max_done got=%0b exp=1", b2.done); end
        checks++; if (b2.episode_cnt !== 16'd1) begin failures++; $display("FAIL max_ep got=%0d exp=1", b2.episode_cnt); end
        checks++; if (b2.at !== 4'd1) begin failures++; $display("FAIL max_at got=%0d exp=1", b2.at); end
        tick();
        checks++; if ({b2.done, b2.at, b2.step_cnt} !== {1'b0, 4'd1, 8'd0}) begin failures++; $display("FAIL max_restart got=%0h exp=100", {b2.done, b2.at, b2.step_cnt}); end
        for (int i = 0; i < 3; i++) begin
            b2.act_valid = 1'b1;
            b2.act = 2'd1;
            tick();
            b2.act_valid = 1'b0;
            if (i == 2) begin
                checks++; if ({b2.s_next, b2.reward, b2.step_cnt} !== {4'd4, 8'h64, 8'd3}) begin failures++; $display("FAIL max_goal got=%0h exp=46403", {b2.s_next, b2.reward, b2.step_cnt}); end
            end
            tick();
        end
        checks++; if ({b2.done, b2.at, b2.episode_cnt} !== {1'b1, 4'd4, 16'd2}) begin failures++; $display("FAIL max_goal_done got=%0h exp=140002", {b2.done, b2.at, b2.episode_cnt}); end
        tick();
        checks++; if ({b2.done, b2.at, b2.episode_cnt} !== {1'b0, 4'd1, 16'd2}) begin failures++; $display("FAIL max_single got=%0h exp=10002", {b2.done, b2.at, b2.episode_cnt}); end
    endtask

    task automatic test_reset_mid_update();
        b0.act_valid = 1'b1;
        b0.act = 2'd2;
        tick();
        b0.act_valid = 1'b0;
        checks++; if (b0.upd_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0b exp=1", b0.upd_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({b0.at, b0.upd_valid, b0.act_ready, b0.done} !== 7'd0) begin failures++; $display("FAIL rmid_state got=%0h exp=0", {b0.at, b0.upd_valid, b0.act_ready, b0.done}); end
        checks++; if ({b0.step_cnt, b0.episode_cnt} !== 24'd0) begin failures++; $display("FAIL rmid_cnt got=%0h exp=0", {b0.step_cnt, b0.episode_cnt}); end
        b0.act_valid = 1'b1;
        b0.act = 2'd1;
        tick();
        tick();
        b0.act_valid = 1'b0;
        checks++; if ({b0.at, b0.act_ready, b0.upd_valid} !== 6'd0) begin failures++; $display("FAIL idle_ignore got=%0h exp=0", {b0.at, b0.act_ready, b0.upd_valid}); end
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        checks++; if ({b0.at, b0.act_ready} !== {4'd1, 1'b1}) begin failures++; $display("FAIL rmid_restart got=%0h exp=3", {b0.at, b0.act_ready}); end
    endtask

    initial begin
        b0.start = 1'b0; b0.act_valid = 1'b0; b0.act = 2'd0;
        b1.start = 1'b0; b1.act_valid = 1'b0; b1.act = 2'd0;
        b2.start = 1'b0; b2.act_valid = 1'b0; b2.act = 2'd0;
        test_reset();
        test_move();
        test_edge();
        test_goal();
        test_back_to_back();
        test_wall();
        test_max_steps();
        test_reset_mid_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
